// File: rtl/wbc_timeout.sv
// Wishbone classic watchdog: registers each request toward the slave and aborts with a bus error
// if no ack/err arrives within TIMEOUT cycles. Define WBC_TIMEOUT_COUNT_EN to add the o_nfaults abort counter.
module wbc_timeout #(
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_scyc,
  input  logic            i_sstb,
  input  logic            i_swe,
  input  logic [AW-1:0]   i_saddr,
  input  logic [DW-1:0]   i_sdata,
  input  logic [DW/8-1:0] i_ssel,
  input  logic [2:0]      i_scti,
  input  logic [1:0]      i_sbte,
  output logic            o_sack,
  output logic            o_serr,
  output logic [DW-1:0]   o_sdata,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  output logic [2:0]      o_mcti,
  output logic [1:0]      o_mbte,
  input  logic            i_mack,
  input  logic            i_merr,
  input  logic [DW-1:0]   i_mdata,
  output logic            o_timeout
`ifdef WBC_TIMEOUT_COUNT_EN
  ,
  output logic [15:0]     o_nfaults
`endif
);

  localparam int unsigned LGTO = $clog2(TIMEOUT + 1);
  localparam logic [LGTO-1:0] LAST = LGTO'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic [LGTO-1:0] r_cnt;
  logic            w_start;
  logic            w_expire;

  // The response guard keeps the strobe that overlaps our ack/err from starting a second cycle.
  assign w_start  = i_scyc && i_sstb && !o_sack && !o_serr;
  assign w_expire = (r_state == S_BUSY) && i_scyc && i_sstb && !i_merr && !i_mack && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      o_mcyc    <= 1'b0;
      o_mstb    <= 1'b0;
      o_sack    <= 1'b0;
      o_serr    <= 1'b0;
      o_timeout <= 1'b0;
      o_sdata   <= '0;
      o_mwe     <= 1'b0;
      o_maddr   <= '0;
      o_mdata   <= '0;
      o_msel    <= '0;
      o_mcti    <= '0;
      o_mbte    <= '0;
    end else begin
      o_sack    <= 1'b0;
      o_serr    <= 1'b0;
      o_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            o_mwe   <= i_swe;
            o_maddr <= i_saddr;
            o_mdata <= i_sdata;
            o_msel  <= i_ssel;
            o_mcti  <= i_scti;
            o_mbte  <= i_sbte;
            o_mcyc  <= 1'b1;
            o_mstb  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!i_scyc || !i_sstb) begin
            o_mcyc  <= 1'b0;
            o_mstb  <= 1'b0;
            r_state <= S_IDLE;
          end else if (i_merr) begin
            o_serr  <= 1'b1;
            o_mcyc  <= 1'b0;
            o_mstb  <= 1'b0;
            r_state <= S_IDLE;
          end else if (i_mack) begin
            o_sack  <= 1'b1;
            o_sdata <= i_mdata;
            o_mcyc  <= 1'b0;
            o_mstb  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == LAST) begin
            o_serr    <= 1'b1;
            o_timeout <= 1'b1;
            o_mcyc    <= 1'b0;
            o_mstb    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + LGTO'(1);
          end
        end
        default: begin
          o_mcyc  <= 1'b0;
          o_mstb  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef WBC_TIMEOUT_COUNT_EN
  // Counts watchdog aborts only, coincident with the o_timeout pulse; sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_nfaults <= 16'h0000;
    end else if (w_expire && (o_nfaults != 16'hFFFF)) begin
      o_nfaults <= o_nfaults + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/wbc_timeout.md
Name: wbc_timeout

Overview:
- Wishbone classic bus watchdog. Sits directly downstream of the WB-pipeline-to-classic bridge, between its classic master port and a classic slave.
- Registers each classic request and forwards it to the slave.
- Returns the slave's ack or err to the bridge.
- If the slave does not respond within TIMEOUT cycles, aborts the cycle and returns a bus error, so a dead slave cannot hang the pipeline master.

Parameters:
AW, 12, address width in words
DW, 32, data width in bits; select width is DW/8
TIMEOUT, 16, max cycles o_mstb is held awaiting ack/err; legal range 2..65535
LGTO, $clog2(TIMEOUT+1), counter width (derived, not overridden)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_scyc, i_sstb, i_swe  in  1 each  upstream classic cycle, strobe, write-enable
i_saddr  in  AW  upstream address
i_sdata  in  DW  upstream write data
i_ssel  in  DW/8  upstream byte selects
i_scti  in  3  upstream cycle type indicator
i_sbte  in  2  upstream burst type
o_sack, o_serr  out  1 each  upstream ack, error
o_sdata  out  DW  upstream read data
o_mcyc, o_mstb, o_mwe  out  1 each  downstream cycle, strobe, write-enable
o_maddr  out  AW  downstream address
o_mdata  out  DW  downstream write data
o_msel  out  DW/8  downstream byte selects
o_mcti  out  3  downstream cycle type indicator
o_mbte  out  2  downstream burst type
i_mack, i_merr  in  1 each  downstream ack, error
i_mdata  in  DW  downstream read data
o_timeout  out  1  one-cycle pulse on each watchdog abort

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE, counter=0.
  - o_mcyc, o_mstb, o_sack, o_serr, o_timeout = 0.
  - Data/address registers are don't-care.
  - A mid-transaction reset drops o_mcyc immediately; no ack or err is issued.
- States: IDLE, BUSY.
- IDLE:
  - Start condition: i_scyc && i_sstb && !o_sack && !o_serr. The ack/err guard stops the strobe cycle that coincides with a response from restarting.
  - On start, next edge: latch we/addr/data/sel/cti/bte into o_m*; o_mcyc=o_mstb=1; counter=0; go to BUSY.
  - Request latency is 1 cycle.
- BUSY, checked in priority order each edge:
  1. !i_scyc || !i_sstb (upstream abort): o_mcyc=o_mstb=0, no o_sack/o_serr, go to IDLE.
  2. i_merr: o_serr=1 for one cycle, o_sack=0 even if i_mack is also high; drop o_mcyc/o_mstb; go to IDLE.
  3. i_mack: o_sack=1 for one cycle, o_sdata<=i_mdata; drop o_mcyc/o_mstb; go to IDLE. Response latency is 1 cycle.
  4. counter==TIMEOUT-1: o_serr=1 and o_timeout=1 for one cycle; drop o_mcyc/o_mstb; go to IDLE.
  5. Otherwise: counter+1.
- Timeout timing:
  - An ack sampled on any of the first TIMEOUT BUSY cycles succeeds.
  - With o_mstb rising in cycle 1, the timeout o_serr appears in cycle TIMEOUT+1.
  - Ack in the final permitted cycle beats timeout.
- Responses arriving while o_mcyc=0 (late acks after abort) are ignored.
- o_m* request fields are stable throughout BUSY.
- o_sack, o_serr and o_timeout are each high for exactly one cycle per event; o_sack and o_serr are never high together.
- o_sdata holds its last value unless i_mack is accepted.
- The counter never wraps; it saturates by leaving BUSY at TIMEOUT-1.

Optional Feature:
- Macro: WBC_TIMEOUT_COUNT_EN.
- Defined:
  - Adds output port o_nfaults, 16 bits.
  - Counts watchdog aborts (o_timeout pulses) only; saturates at 16'hFFFF.
  - Async reset to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Read, slave acks 3 cycles after o_mstb rises, i_mdata=32'hCAFEF00D, TIMEOUT=16 -> o_sack one cycle later with o_sdata=32'hCAFEF00D, o_serr=0, o_timeout=0, o_mcyc low the cycle after.
- Write addr 12'h123, data 32'h55AA55AA, sel 4'b0011, slave silent -> o_m* fields stable 16 cycles; o_serr and o_timeout pulse in cycle 17; o_mcyc=0; later i_mack ignored (no o_sack).
- Ack on the 16th BUSY cycle (TIMEOUT=16) -> o_sack=1, o_serr=0, o_timeout=0.
- i_mack and i_merr high together -> o_serr=1, o_sack=0, o_timeout=0.
- Upstream drops i_scyc 2 cycles into BUSY -> o_mcyc=0 next edge, no o_sack/o_serr; a new request 2 cycles later is accepted with counter restarted at 0.
- i_reset pulsed asynchronously mid-BUSY -> o_mcyc/o_mstb low immediately; with WBC_TIMEOUT_COUNT_EN, o_nfaults=0. After three forced timeouts, o_nfaults=3.
